axi_slv_mem: RTL

AXI_SLV_MEM -- requirements
Module: axi_slv_mem

---
 rtl/axi_slv_mem.sv | 362 ++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_slv_mem.sv
// axi_slv_mem: memory-backed AXI4 subordinate, one write and one read in flight.
// Define AXI_SLV_MEM_BOUNDS_CHK_EN to flag out-of-range word indices with SLVERR.
module axi_slv_mem #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 4,
   parameter int AXI_USER_WIDTH = 1,
   parameter int MEM_WORDS      = 1024
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [AXI_ID_WIDTH-1:0]     aw_id,
   input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
   input  logic [7:0]                  aw_len,
   input  logic [2:0]                  aw_size,
   input  logic [1:0]                  aw_burst,
   input  logic                        aw_lock,
   input  logic [3:0]                  aw_cache,
   input  logic [2:0]                  aw_prot,
   input  logic [3:0]                  aw_qos,
   input  logic [3:0]                  aw_region,
   input  logic [5:0]                  aw_atop,
   input  logic [AXI_USER_WIDTH-1:0]   aw_user,
   input  logic                        aw_valid,
   output logic                        aw_ready,
   input  logic [AXI_DATA_WIDTH-1:0]   w_data,
   input  logic [AXI_DATA_WIDTH/8-1:0] w_strb,
   input  logic                        w_last,
   input  logic [AXI_USER_WIDTH-1:0]   w_user,
   input  logic                        w_valid,
   output logic                        w_ready,
   output logic [AXI_ID_WIDTH-1:0]     b_id,
   output logic [1:0]                  b_resp,
   output logic [AXI_USER_WIDTH-1:0]   b_user,
   output logic                        b_valid,
   input  logic                        b_ready,
   input  logic [AXI_ID_WIDTH-1:0]     ar_id,
   input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
   input  logic [7:0]                  ar_len,
   input  logic [2:0]                  ar_size,
   input  logic [1:0]                  ar_burst,
   input  logic                        ar_lock,
   input  logic [3:0]                  ar_cache,
   input  logic [2:0]                  ar_prot,
   input  logic [3:0]                  ar_qos,
   input  logic [3:0]                  ar_region,
   input  logic [AXI_USER_WIDTH-1:0]   ar_user,
   input  logic                        ar_valid,
   output logic                        ar_ready,
   output logic [AXI_ID_WIDTH-1:0]     r_id,
   output logic [AXI_DATA_WIDTH-1:0]   r_data,
   output logic [1:0]                  r_resp,
   output logic                        r_last,
   output logic [AXI_USER_WIDTH-1:0]   r_user,
   output logic                        r_valid,
   input  logic                        r_ready
);

   localparam int STRB  = AXI_DATA_WIDTH / 8;
   localparam int SHIFT = $clog2(STRB);
   localparam int IDX_W = $clog2(MEM_WORDS);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef logic [AXI_ADDR_WIDTH-1:0] addr_t;
   typedef logic [AXI_DATA_WIDTH-1:0] data_t;
   typedef logic [AXI_ID_WIDTH-1:0]   id_t;
   typedef logic [AXI_USER_WIDTH-1:0] user_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } w_state_e;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } r_state_e;

   // Address of the beat following a, for FIXED / INCR / WRAP bursts.
   function automatic addr_t next_addr(
      input addr_t      a,
      input logic [7:0] len,
      input logic [2:0] size,
      input logic [1:0] burst
   );
      addr_t step;
      addr_t mask;
      addr_t nxt;
      step = addr_t'(1) << size;
      mask = ((addr_t'(len) + addr_t'(1)) << size) - addr_t'(1);
      case (burst)
         BURST_INCR: nxt = a + step;
         BURST_WRAP: nxt = (a & ~mask) | ((a + step) & mask);
         default:    nxt = a;
      endcase
      return nxt;
   endfunction

   // Burst attributes that make every beat of the burst an error.
   function automatic logic attr_err(
      input logic [2:0] size,
      input logic [1:0] burst,
      input logic [7:0] len
   );
      logic bad_len;
      bad_len = !((len == 8'd1) || (len == 8'd3) ||
                  (len == 8'd7) || (len == 8'd15));
      return (int'(size) > SHIFT) || (burst == 2'b11) ||
             ((burst == BURST_WRAP) && bad_len);
   endfunction

   data_t mem_q [MEM_WORDS];

   w_state_e   w_state_q, w_state_d;
   id_t        w_id_q, w_id_d;
   user_t      w_user_q, w_user_d;
   addr_t      w_addr_q, w_addr_d;
   logic [7:0] w_len_q, w_len_d;
   logic [7:0] w_cnt_q, w_cnt_d;
   logic [2:0] w_size_q, w_size_d;
   logic [1:0] w_burst_q, w_burst_d;
   logic       w_aerr_q, w_aerr_d;
   logic       w_err_q, w_err_d;

   r_state_e   r_state_q, r_state_d;
   id_t        r_id_q, r_id_d;
   user_t      r_user_q, r_user_d;
   addr_t      r_addr_q, r_addr_d;
   logic [7:0] r_len_q, r_len_d;
   logic [7:0] r_cnt_q, r_cnt_d;
   logic [2:0] r_size_q, r_size_d;
   logic [1:0] r_burst_q, r_burst_d;
   logic       r_aerr_q, r_aerr_d;
   data_t      r_data_q, r_data_d;
   logic [1:0] r_resp_q, r_resp_d;
   logic       r_last_q, r_last_d;

   logic             w_oob;
   logic             w_beat_err;
   logic             w_wen;
   logic [IDX_W-1:0] w_idx;
   addr_t            r_nxt_addr;
   addr_t            rd_addr;
   logic             r_oob;
   logic             r_beat_err;
   logic [IDX_W-1:0] r_idx;
   data_t            rd_word;
   logic             unused_ok;

`ifdef AXI_SLV_MEM_BOUNDS_CHK_EN
   assign w_oob = (w_addr_q >> SHIFT) >= addr_t'(MEM_WORDS);
   assign r_oob = (rd_addr >> SHIFT) >= addr_t'(MEM_WORDS);
`else
   assign w_oob = 1'b0;
   assign r_oob = 1'b0;
`endif

   assign unused_ok = ^{aw_lock, aw_cache, aw_prot, aw_qos, aw_region,
                        ar_lock, ar_cache, ar_prot, ar_qos, ar_region,
                        w_user, rd_addr};

   // ---------------- write engine ----------------
   assign w_idx      = w_addr_q[SHIFT +: IDX_W];
   assign w_beat_err = w_aerr_q || w_oob ||
                       (w_last && (w_cnt_q != w_len_q));
   assign w_wen      = (w_state_q == W_DATA) && w_valid &&
                       !w_beat_err && !rst;

   assign b_id   = w_id_q;
   assign b_user = w_user_q;
   assign b_resp = w_err_q ? RESP_SLVERR : RESP_OKAY;

   // Write FSM next state, AW capture, beat counting and sticky error.
   always_comb begin
      w_state_d = w_state_q;
      w_id_d    = w_id_q;
      w_user_d  = w_user_q;
      w_addr_d  = w_addr_q;
      w_len_d   = w_len_q;
      w_cnt_d   = w_cnt_q;
      w_size_d  = w_size_q;
      w_burst_d = w_burst_q;
      w_aerr_d  = w_aerr_q;
      w_err_d   = w_err_q;
      aw_ready  = 1'b0;
      w_ready   = 1'b0;
      b_valid   = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            aw_ready = 1'b1;
            if (aw_valid) begin
               w_id_d    = aw_id;
               w_user_d  = aw_user;
               w_addr_d  = aw_addr;
               w_len_d   = aw_len;
               w_size_d  = aw_size;
               w_burst_d = aw_burst;
               w_cnt_d   = 8'd0;
               w_err_d   = 1'b0;
               w_aerr_d  = attr_err(aw_size, aw_burst, aw_len) ||
                           (aw_atop != 6'd0);
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            w_ready = 1'b1;
            if (w_valid) begin
               w_err_d  = w_err_q || w_beat_err;
               w_addr_d = next_addr(w_addr_q, w_len_q,
                                    w_size_q, w_burst_q);
               w_cnt_d  = w_cnt_q + 8'd1;
               if (w_cnt_q == w_len_q) begin
                  w_state_d = W_RESP;
               end
            end
         end
         W_RESP: begin
            b_valid = 1'b1;
            if (b_ready) begin
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Byte-lane write of accepted error-free beats; contents survive reset.
   always_ff @(posedge clk) begin
      if (w_wen) begin
         for (int b = 0; b < STRB; b++) begin
            if (w_strb[b]) begin
               mem_q[w_idx][b*8 +: 8] <= w_data[b*8 +: 8];
            end
         end
      end
   end

   // ---------------- read engine ----------------
   assign r_nxt_addr = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
   assign rd_addr    = (r_state_q == R_IDLE) ? ar_addr : r_nxt_addr;
   assign r_idx      = rd_addr[SHIFT +: IDX_W];
   assign rd_word    = mem_q[r_idx];

   assign r_id   = r_id_q;
   assign r_user = r_user_q;
   assign r_data = r_data_q;
   assign r_resp = r_resp_q;
   assign r_last = r_last_q;

   // Read FSM next state; each beat's data is fetched one cycle ahead.
   always_comb begin
      r_state_d  = r_state_q;
      r_id_d     = r_id_q;
      r_user_d   = r_user_q;
      r_addr_d   = r_addr_q;
      r_len_d    = r_len_q;
      r_cnt_d    = r_cnt_q;
      r_size_d   = r_size_q;
      r_burst_d  = r_burst_q;
      r_aerr_d   = r_aerr_q;
      r_data_d   = r_data_q;
      r_resp_d   = r_resp_q;
      r_last_d   = r_last_q;
      r_beat_err = 1'b0;
      ar_ready   = 1'b0;
      r_valid    = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            ar_ready = 1'b1;
            if (ar_valid) begin
               r_id_d     = ar_id;
               r_user_d   = ar_user;
               r_addr_d   = ar_addr;
               r_len_d    = ar_len;
               r_size_d   = ar_size;
               r_burst_d  = ar_burst;
               r_cnt_d    = 8'd0;
               r_aerr_d   = attr_err(ar_size, ar_burst, ar_len);
               r_beat_err = r_aerr_d || r_oob;
               r_data_d   = r_beat_err ? '0 : rd_word;
               r_resp_d   = r_beat_err ? RESP_SLVERR : RESP_OKAY;
               r_last_d   = (ar_len == 8'd0);
               r_state_d  = R_DATA;
            end
         end
         R_DATA: begin
            r_valid = 1'b1;
            if (r_ready) begin
               if (r_last_q) begin
                  r_last_d  = 1'b0;
                  r_state_d = R_IDLE;
               end else begin
                  r_beat_err = r_aerr_q || r_oob;
                  r_addr_d   = r_nxt_addr;
                  r_cnt_d    = r_cnt_q + 8'd1;
                  r_data_d   = r_beat_err ? '0 : rd_word;
                  r_resp_d   = r_beat_err ? RESP_SLVERR : RESP_OKAY;
                  r_last_d   = ((r_cnt_q + 8'd1) == r_len_q);
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // State and payload registers of both engines.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         w_id_q    <= '0;
         w_user_q  <= '0;
         w_addr_q  <= '0;
         w_len_q   <= '0;
         w_cnt_q   <= '0;
         w_size_q  <= '0;
         w_burst_q <= '0;
         w_aerr_q  <= 1'b0;
         w_err_q   <= 1'b0;
         r_state_q <= R_IDLE;
         r_id_q    <= '0;
         r_user_q  <= '0;
         r_addr_q  <= '0;
         r_len_q   <= '0;
         r_cnt_q   <= '0;
         r_size_q  <= '0;
         r_burst_q <= '0;
         r_aerr_q  <= 1'b0;
         r_data_q  <= '0;
         r_resp_q  <= RESP_OKAY;
         r_last_q  <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         w_id_q    <= w_id_d;
         w_user_q  <= w_user_d;
         w_addr_q  <= w_addr_d;
         w_len_q   <= w_len_d;
         w_cnt_q   <= w_cnt_d;
         w_size_q  <= w_size_d;
         w_burst_q <= w_burst_d;
         w_aerr_q  <= w_aerr_d;
         w_err_q   <= w_err_d;
         r_state_q <= r_state_d;
         r_id_q    <= r_id_d;
         r_user_q  <= r_user_d;
         r_addr_q  <= r_addr_d;
         r_len_q   <= r_len_d;
         r_cnt_q   <= r_cnt_d;
         r_size_q  <= r_size_d;
         r_burst_q <= r_burst_d;
         r_aerr_q  <= r_aerr_d;
         r_data_q  <= r_data_d;
         r_resp_q  <= r_resp_d;
         r_last_q  <= r_last_d;
      end
   end

endmodule
